// File: rtl/pwm_duty_decoder.sv
// Measures high time and period of an external PWM input and reports the duty
// cycle quantised to a 0-9 level, suitable for a single 7-segment digit.
module pwm_duty_decoder #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_i,
  output logic [3:0] level_o,
  output logic       valid_o,
  output logic       busy_o
);

  localparam int unsigned ACC_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] TMO_HIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_PRE = CNT_W'(TIMEOUT - 2);
  localparam logic [3:0] LVL_MAX = 4'd9;
  localparam logic [3:0] Q_MAX   = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_LOAD,
    ST_DIV,
    ST_DONE
  } state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic               rise;
  logic               tmo;
  logic               tmo_soon;
  logic [CNT_W-1:0]   period_cnt;
  logic [CNT_W-1:0]   high_cnt;
  logic [CNT_W-1:0]   snap_per;
  logic [CNT_W-1:0]   snap_hi;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   hi_x10;
  logic [ACC_W-1:0]   per_ext;
  logic [3:0]         q;
  logic [3:0]         q_clamped;
  logic               div_step;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Two-flop synchroniser plus one delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // The counter "reaches" TIMEOUT on the increment from TIMEOUT-1, so a static
  // input yields exactly one result every TIMEOUT cycles.
  assign tmo      = (period_cnt == TMO_HIT);
  assign tmo_soon = (period_cnt == TMO_PRE) & ~rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (tmo) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else begin
      period_cnt <= sat_inc(period_cnt);
      if (s2) begin
        high_cnt <= sat_inc(high_cnt);
      end
    end
  end

  assign hi_x10    = (ACC_W'(snap_hi) << 3) + (ACC_W'(snap_hi) << 1);
  assign per_ext   = ACC_W'(snap_per);
  assign div_step  = (acc >= per_ext) && (q < Q_MAX);
  assign q_clamped = (q > LVL_MAX) ? LVL_MAX : q;

  // Measurement / restoring-divide sequencer; timeout overrides every state.
  // A timeout due in the DONE cycle suppresses the division pulse so only the
  // static-level result is reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      snap_per <= '0;
      snap_hi  <= '0;
      acc      <= '0;
      q        <= '0;
      level_o  <= '0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (tmo) begin
        state   <= ST_IDLE;
        busy_o  <= 1'b0;
        valid_o <= 1'b1;
        level_o <= s2 ? LVL_MAX : 4'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (rise) begin
              snap_per <= period_cnt;
              snap_hi  <= high_cnt;
              busy_o   <= 1'b1;
              state    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            acc   <= hi_x10;
            q     <= 4'd0;
            state <= ST_DIV;
          end
          ST_DIV: begin
            if (div_step) begin
              acc <= acc - per_ext;
              q   <= q + 4'd1;
            end else begin
              state <= ST_DONE;
              if (!tmo_soon) begin
                level_o <= q_clamped;
                valid_o <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            busy_o <= 1'b0;
            state  <= ST_MEASURE;
          end
          default: begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: drives PWM patterns and compares every result
// pulse against a period/duty reference model.
module tb_pwm_duty_decoder;

  localparam int TMO = 200;

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
    logic       busy;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwm_i;
  logic [3:0] level_o;
  logic       valid_o;
  logic       busy_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hold_bad = 0;
  logic [3:0] prev_lvl = 4'd0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  obs_rd = 0;

  // Reference model state, expressed in cycles at which s2 reflects the input
  logic m_prev;
  bit   m_armed;
  int   m_last_rise, m_zero, m_done, m_hi;

  pwm_duty_decoder #(.CNT_W(16), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_i   (pwm_i),
    .level_o (level_o),
    .valid_o (valid_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse and any level change outside a pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_lvl <= 4'd0;
    end else begin
      if (valid_o) obs_q.push_back('{cyc, level_o, busy_o});
      else if (level_o !== prev_lvl) hold_bad <= hold_bad + 1;
      prev_lvl <= level_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset(input int c);
    m_prev      = 1'b0;
    m_armed     = 1'b0;
    m_zero      = c;
    m_done      = 0;
    m_hi        = 0;
    m_last_rise = c;
  endtask

  // Drive one input cycle and update the expected-result list
  task automatic drive(input logic v);
    int t;
    int qv;
    logic [3:0] lvl;
    @(negedge clk);
    pwm_i = v;
    t = cyc + 2;
    if (t == m_zero + TMO - 1) begin
      while (exp_q.size() != 0 && exp_q[$].cyc >= t) void'(exp_q.pop_back());
      exp_q.push_back('{t + 1, v ? 4'd9 : 4'd0, 1'b0});
      m_zero  = t + 1;
      m_armed = 1'b0;
      m_done  = 0;
    end else if (v && !m_prev) begin
      if (m_armed && t > m_done) begin
        qv = (10 * m_hi) / (t - m_last_rise);
        if (qv > 10) qv = 10;
        lvl = (qv > 9) ? 4'd9 : 4'(qv);
        exp_q.push_back('{t + qv + 3, lvl, 1'b1});
        m_done = t + qv + 3;
      end
      m_armed     = 1'b1;
      m_last_rise = t;
      m_zero      = t;
      m_hi        = 0;
    end
    if (v) m_hi++;
    m_prev = v;
  endtask

  task automatic drive_period(input int h, input int p);
    repeat (h) drive(1'b1);
    repeat (p - h) drive(1'b0);
  endtask

  // Let pending results emerge, then match observed pulses to expected ones
  task automatic compare_all(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && cyc <= exp_q[$].cyc + 1 && guard < 64) begin
      drive(m_prev);
      guard++;
    end
    drive(m_prev);
    chk({tag, " pulses"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_rd + i >= obs_q.size()) break;
      chk({tag, " cycle"}, 32'(obs_q[obs_rd + i].cyc), 32'(exp_q[i].cyc));
      chk({tag, " level"}, 32'(obs_q[obs_rd + i].lvl), 32'(exp_q[i].lvl));
      chk({tag, " busy"},  32'(obs_q[obs_rd + i].busy), 32'(exp_q[i].busy));
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  initial begin
    int p;
    int h;
    rst_n = 1'b0;
    pwm_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset level", 32'(level_o), 32'd0);
    chk("reset valid", 32'(valid_o), 32'd0);
    chk("reset busy",  32'(busy_o),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(cyc);
    repeat (5) drive(1'b0);

    // Basic decode and boundary duty levels
    repeat (5) drive_period(30, 100);
    drive_period(99, 100);
    drive_period(1, 100);
    drive_period(50, 100);
    repeat (4) drive_period(10, 20);
    // Random periods long enough that every one is decoded
    repeat (10) begin
      p = int'($urandom_range(190, 14));
      h = int'($urandom_range(p - 1, 1));
      drive_period(h, p);
    end
    drive_period(5, 30);
    compare_all("pwm");

    // Static low then static high: periodic timeout results
    repeat (650) drive(1'b0);
    compare_all("static_low");
    repeat (650) drive(1'b1);
    compare_all("static_high");

    // Resume: first edge only arms the measurement
    repeat (5) drive(1'b0);
    repeat (3) drive_period(40, 100);
    compare_all("resume");

    // Short periods: edges during the divide drop their period
    repeat (8) drive_period(4, 8);
    drive_period(30, 100);
    compare_all("short");

    // Timeout coinciding with a rising edge
    drive_period(10, 50);
    drive_period(10, TMO - 1);
    drive_period(20, 60);
    drive_period(20, 60);
    drive_period(5, 30);
    compare_all("priority");

    // Reset during the divide
    drive_period(50, 100);
    drive_period(50, 100);
    repeat (4) drive(1'b1);
    @(negedge clk);
    chk("busy before reset", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    pwm_i = 1'b0;
    #1;
    chk("midreset level", 32'(level_o), 32'd0);
    chk("midreset valid", 32'(valid_o), 32'd0);
    chk("midreset busy",  32'(busy_o),  32'd0);
    while (exp_q.size() != 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset(cyc);
    repeat (5) drive(1'b0);
    repeat (3) drive_period(25, 100);
    drive_period(5, 30);
    compare_all("after_reset");

    chk("level hold", 32'(hold_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
